// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP fetch scheduler: FSM encoding, window slot indices
// and the slot-to-(dr,dc) offset table used to generate neighbourhood read addresses.
package lbp_pkg;

  localparam int IMG_LOG2_DEF = 7;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_SLIDE, S_EMIT, S_DONE} state_t;

  // Slot k = 3*dr + dc relative to (row-1, col-1)
  localparam logic [3:0] K_TL = 4'd0;
  localparam logic [3:0] K_TR = 4'd2;
  localparam logic [3:0] K_C  = 4'd4;
  localparam logic [3:0] K_BR = 4'd8;

  localparam logic [3:0] FILL_LAST  = 4'd8;
  localparam logic [3:0] SLIDE_LAST = 4'd2;

  typedef struct packed {
    logic [1:0] dr;
    logic [1:0] dc;
  } slot_off_t;

  function automatic slot_off_t slot_off(input logic [3:0] k);
    case (k)
      4'd0:    return '{dr: 2'd0, dc: 2'd0};
      4'd1:    return '{dr: 2'd0, dc: 2'd1};
      4'd2:    return '{dr: 2'd0, dc: 2'd2};
      4'd3:    return '{dr: 2'd1, dc: 2'd0};
      4'd5:    return '{dr: 2'd1, dc: 2'd2};
      4'd6:    return '{dr: 2'd2, dc: 2'd0};
      4'd7:    return '{dr: 2'd2, dc: 2'd1};
      4'd8:    return '{dr: 2'd2, dc: 2'd2};
      default: return '{dr: 2'd1, dc: 2'd1};
    endcase
  endfunction

endpackage

// File: rtl/lbp_win_regs.sv
// 3x3 pixel window register: column shift for the sliding window plus a single
// slot write port fed by the read-return pipe.
module lbp_win_regs
  import lbp_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               shift_en,
  input  logic               wr_en,
  input  logic [3:0]         wr_slot,
  input  logic [PIX_W-1:0]   wr_data,
  output logic [9*PIX_W-1:0] win_data
);

  logic [PIX_W-1:0] slot_q [9];

  // NOTE: the slots are a small register array, not a RAM, so they take the reset
  // like any other flop; this keeps win_data at zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 9; k++) slot_q[k] <= '0;
    end else begin
      if (shift_en) begin
        for (int r = 0; r < 3; r++) begin
          slot_q[3*r]   <= slot_q[3*r+1];
          slot_q[3*r+1] <= slot_q[3*r+2];
        end
      end
      if (wr_en && (wr_slot <= K_BR)) slot_q[wr_slot] <= wr_data;
    end
  end

  for (genvar k = 0; k < 9; k++) begin : g_pack
    assign win_data[PIX_W*k +: PIX_W] = slot_q[k];
  end

endmodule

// File: rtl/lbp_fetch_sched.sv
// Raster-scan fetch scheduler: walks the image, issues gray-memory reads to build
// each 3x3 window and hands windows downstream over valid/ready.
module lbp_fetch_sched
  import lbp_pkg::*;
#(
  parameter int IMG_LOG2 = IMG_LOG2_DEF,
  parameter int PIX_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  gray_ready,
  output logic                  gray_req,
  output logic [2*IMG_LOG2-1:0] gray_addr,
  input  logic [PIX_W-1:0]      gray_data,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [2*IMG_LOG2-1:0] win_addr,
  output logic                  win_edge,
  output logic [9*PIX_W-1:0]    win_data,
  output logic                  finish
);

  localparam logic [IMG_LOG2-1:0] LAST = '1;

  state_t              state;
  logic [IMG_LOG2-1:0] row, col;
  logic [3:0]          cnt, cur_slot, rd_slot;
  logic                rd_vld;
  logic                is_border, dispatch, shift_en;

  function automatic logic [2*IMG_LOG2-1:0] slot_addr(input logic [IMG_LOG2-1:0] r,
                                                       input logic [IMG_LOG2-1:0] c,
                                                       input logic [3:0]          k);
    slot_off_t           o;
    logic [IMG_LOG2-1:0] ar, ac;
    o  = slot_off(k);
    ar = r + IMG_LOG2'(o.dr) - IMG_LOG2'(1);
    ac = c + IMG_LOG2'(o.dc) - IMG_LOG2'(1);
    return {ar, ac};
  endfunction

  assign is_border = (row == '0) || (row == LAST) || (col == '0) || (col == LAST);
  // NOTE: the EMIT cycle with win_valid low is the dispatch slot after a handshake;
  // win_valid itself is a flop, so win_ready never reaches it combinationally.
  assign dispatch  = ((state == S_IDLE) && gray_ready) || ((state == S_EMIT) && !win_valid);
  assign shift_en  = (state == S_SLIDE) && (cnt == '0);

  // NOTE: all state below uses non-blocking assignments so every flop samples
  // pre-edge values; reset is asynchronous and aborts any frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      row       <= '0;
      col       <= '0;
      cnt       <= '0;
      cur_slot  <= '0;
      rd_slot   <= '0;
      rd_vld    <= 1'b0;
      gray_req  <= 1'b0;
      gray_addr <= '0;
      win_valid <= 1'b0;
      win_edge  <= 1'b0;
      win_addr  <= '0;
      finish    <= 1'b0;
    end else begin
      rd_vld  <= gray_req;
      rd_slot <= cur_slot;
      if (dispatch) begin
        win_addr <= {row, col};
        win_edge <= is_border;
        cnt      <= '0;
        if (is_border) begin
          state     <= S_EMIT;
          win_valid <= 1'b1;
        end else if (col == IMG_LOG2'(1)) begin
          state     <= S_FILL;
          gray_req  <= 1'b1;
          cur_slot  <= K_TL;
          gray_addr <= slot_addr(row, col, K_TL);
        end else begin
          state     <= S_SLIDE;
          gray_req  <= 1'b1;
          cur_slot  <= K_TR;
          gray_addr <= slot_addr(row, col, K_TR);
        end
      end else begin
        case (state)
          S_FILL: begin
            if (cnt < FILL_LAST) begin
              cnt       <= cnt + 4'd1;
              cur_slot  <= cur_slot + 4'd1;
              gray_addr <= slot_addr(row, col, cur_slot + 4'd1);
            end else if (cnt == FILL_LAST) begin
              gray_req <= 1'b0;
              cnt      <= cnt + 4'd1;
            end else begin
              state     <= S_EMIT;
              win_valid <= 1'b1;
            end
          end
          S_SLIDE: begin
            // Only the right column is fetched: slots 2, 5, 8
            if (cnt < SLIDE_LAST) begin
              cnt       <= cnt + 4'd1;
              cur_slot  <= cur_slot + 4'd3;
              gray_addr <= slot_addr(row, col, cur_slot + 4'd3);
            end else if (cnt == SLIDE_LAST) begin
              gray_req <= 1'b0;
              cnt      <= cnt + 4'd1;
            end else begin
              state     <= S_EMIT;
              win_valid <= 1'b1;
            end
          end
          S_EMIT: begin
            if (win_valid && win_ready) begin
              win_valid <= 1'b0;
              if ((row == LAST) && (col == LAST)) begin
                state  <= S_DONE;
                finish <= 1'b1;
              end else begin
                col <= col + IMG_LOG2'(1);
                if (col == LAST) row <= row + IMG_LOG2'(1);
              end
            end
          end
          S_IDLE:  ;
          S_DONE:  ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  lbp_win_regs #(.PIX_W(PIX_W)) u_win_regs (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .wr_en    (rd_vld),
    .wr_slot  (rd_slot),
    .wr_data  (gray_data),
    .win_data (win_data)
  );

endmodule

// File: tb/tb_lbp_fetch_sched.sv
// Directed bench: a 4x4 instance walks a full frame against a hand-built vector table;
// a 128x128 instance covers backpressure and mid-frame reset against a pixel model.
module tb_lbp_fetch_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nerr = 0;
  int nchk = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- small instance, N=4, pixel = row*4+col ----------------
  logic        s_reset, s_ready, s_req, s_valid, s_wr, s_edge, s_fin;
  logic [3:0]  s_addr, s_waddr;
  logic [7:0]  s_data;
  logic [71:0] s_wdata;

  always @(posedge clk) if (s_req) s_data <= {4'b0, s_addr};

  lbp_fetch_sched #(.IMG_LOG2(2), .PIX_W(8)) u_small (
    .clk(clk), .reset(s_reset), .gray_ready(s_ready), .gray_req(s_req), .gray_addr(s_addr),
    .gray_data(s_data), .win_valid(s_valid), .win_ready(s_wr), .win_addr(s_waddr),
    .win_edge(s_edge), .win_data(s_wdata), .finish(s_fin)
  );

  int   s_reads = 0, s_hs = 0, s_start = 0;
  logic s_req_q = 1'b0;
  always @(negedge clk) begin
    if (s_req && !s_req_q) s_start = cyc;
    s_req_q = s_req;
    if (s_req) s_reads++;
    if (s_valid && s_wr) s_hs++;
  end

  // ---------------- large instance, N=128, hashed image ----------------
  logic        l_reset, l_ready, l_req, l_valid, l_wr, l_edge, l_fin;
  logic [13:0] l_addr, l_waddr;
  logic [7:0]  l_data;
  logic [71:0] l_wdata;

  function automatic logic [7:0] pixl(input logic [6:0] r, input logic [6:0] c);
    logic [7:0] v;
    v = 8'(int'(r) * 37 + int'(c) * 11);
    return v ^ {1'b0, r ^ c};
  endfunction

  function automatic logic [71:0] golden(input int r, input int c);
    logic [71:0] d;
    for (int k = 0; k < 9; k++) d[8*k +: 8] = pixl(7'(r + k/3 - 1), 7'(c + k%3 - 1));
    return d;
  endfunction

  always @(posedge clk) if (l_req) l_data <= pixl(l_addr[13:7], l_addr[6:0]);

  lbp_fetch_sched #(.IMG_LOG2(7), .PIX_W(8)) u_large (
    .clk(clk), .reset(l_reset), .gray_ready(l_ready), .gray_req(l_req), .gray_addr(l_addr),
    .gray_data(l_data), .win_valid(l_valid), .win_ready(l_wr), .win_addr(l_waddr),
    .win_edge(l_edge), .win_data(l_wdata), .finish(l_fin)
  );

  // ---------------- vector table for the 4x4 frame ----------------
  typedef struct {
    logic [1:0] r;
    logic [1:0] c;
    logic       brd;
    int         s[9];
  } vec_t;

  vec_t vt[16];

  function automatic logic [71:0] pack9(input int s[9]);
    logic [71:0] d;
    for (int k = 0; k < 9; k++) d[8*k +: 8] = 8'(s[k]);
    return d;
  endfunction

  task automatic s_wait_valid(output bit ok);
    int n = 0;
    while (!s_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    ok = s_valid;
  endtask

  task automatic l_wait_valid(output bit ok);
    int n = 0;
    while (!l_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    ok = l_valid;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          ok;
    int          n;
    bit          stable, req_seen;
    logic [13:0] snap_addr;
    logic [71:0] snap_data;

    for (int i = 0; i < 16; i++) begin
      vt[i].r   = 2'(i / 4);
      vt[i].c   = 2'(i % 4);
      vt[i].brd = (i / 4 == 0) || (i / 4 == 3) || (i % 4 == 0) || (i % 4 == 3);
      vt[i].s   = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    end
    vt[5].s  = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    vt[6].s  = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    vt[9].s  = '{4, 5, 6, 8, 9, 10, 12, 13, 14};
    vt[10].s = '{5, 6, 7, 9, 10, 11, 13, 14, 15};

    s_reset = 1'b1; s_ready = 1'b1; s_wr = 1'b1;
    l_reset = 1'b1; l_ready = 1'b1; l_wr = 1'b1;
    repeat (3) @(negedge clk);

    // reset held with gray_ready high: everything quiet
    check("rst_gray_req",  s_req,   1'b0);
    check("rst_win_valid", s_valid, 1'b0);
    check("rst_win_edge",  s_edge,  1'b0);
    check("rst_finish",    s_fin,   1'b0);
    check("rst_gray_addr", s_addr,  4'h0);
    check("rst_win_addr",  s_waddr, 4'h0);
    check("rst_win_data",  s_wdata, 72'h0);

    s_reset = 1'b0;
    @(negedge clk);
    check("first_valid", s_valid, 1'b1);

    for (int i = 0; i < 16; i++) begin
      s_wait_valid(ok);
      check($sformatf("s_valid_%0d", i), ok, 1'b1);
      check($sformatf("s_addr_%0d", i), s_waddr, {vt[i].r, vt[i].c});
      check($sformatf("s_edge_%0d", i), s_edge, vt[i].brd);
      if (!vt[i].brd) check($sformatf("s_data_%0d", i), s_wdata, pack9(vt[i].s));
      if (i == 5) check("fill_latency", cyc - s_start, 10);
      if (i == 6) check("slide_latency", cyc - s_start, 4);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("s_finish",     s_fin,   1'b1);
    check("s_done_valid", s_valid, 1'b0);
    check("s_done_req",   s_req,   1'b0);
    check("s_reads",      s_reads, 24);
    check("s_handshakes", s_hs,    16);

    // ---------------- large: backpressure at (5,7) ----------------
    l_reset = 1'b0;
    n = 0;
    while (!(l_valid && l_waddr == {7'd5, 7'd7}) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    l_wr = 1'b0;
    check("l_57_found", l_valid && l_waddr == {7'd5, 7'd7}, 1'b1);
    check("l_57_edge",  l_edge,  1'b0);
    check("l_57_data",  l_wdata, golden(5, 7));
    snap_addr = l_waddr;
    snap_data = l_wdata;
    stable    = 1'b1;
    req_seen  = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (!l_valid || l_waddr !== snap_addr || l_wdata !== snap_data || l_edge !== 1'b0)
        stable = 1'b0;
      if (l_req) req_seen = 1'b1;
    end
    check("l_stall_stable", stable,   1'b1);
    check("l_stall_noreq",  req_seen, 1'b0);
    l_wr = 1'b1;
    @(negedge clk);
    l_wait_valid(ok);
    check("l_58_valid", ok,      1'b1);
    check("l_58_addr",  l_waddr, {7'd5, 7'd8});
    check("l_58_data",  l_wdata, golden(5, 8));

    // ---------------- large: reset during SLIDE of (40,60) ----------------
    n = 0;
    while (!(l_req && l_waddr == {7'd40, 7'd60} && l_addr == {7'd39, 7'd61}) && n < 40000) begin
      @(negedge clk);
      n++;
    end
    check("l_slide_found", l_req && l_waddr == {7'd40, 7'd60}, 1'b1);
    l_reset = 1'b1;
    #1;
    check("l_rst_req",   l_req,   1'b0);
    check("l_rst_valid", l_valid, 1'b0);
    check("l_rst_edge",  l_edge,  1'b0);
    check("l_rst_fin",   l_fin,   1'b0);
    check("l_rst_gaddr", l_addr,  14'h0);
    check("l_rst_waddr", l_waddr, 14'h0);
    check("l_rst_wdata", l_wdata, 72'h0);
    @(negedge clk);
    l_reset = 1'b0;
    @(negedge clk);
    check("l_restart_valid", l_valid, 1'b1);
    check("l_restart_addr",  l_waddr, 14'h0);
    check("l_restart_edge",  l_edge,  1'b1);
    check("l_restart_fin",   l_fin,   1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
